// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush controller
//
// Purpose: derives PC enable and per-stage-register enable/clear from
// hazard inputs, tracks multi-cycle ops (MCWAIT) and wrong-path fetch
// drain (DRAIN), and counts stalled cycles.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_ifetch_busy                  IF has no valid instruction this cycle
//   i_dmem_busy                    MEM data access not complete
//   i_load_use                     load-use hazard between ID and EX
//   i_redirect                     EX resolved a control transfer
//   i_mc_start, i_mc_done          multi-cycle op start / result ready
//   o_pc_en                        PC update enable
//   o_<stage>_en, o_<stage>_clr    stage register hold/capture/bubble
//   o_state                        RUN=0, MCWAIT=1, DRAIN=2
//   o_stall_cycles                 saturating count of pc_en=0 cycles
module pipe_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ifetch_busy,
   input  logic             i_dmem_busy,
   input  logic             i_load_use,
   input  logic             i_redirect,
   input  logic             i_mc_start,
   input  logic             i_mc_done,
   output logic             o_pc_en,
   output logic             o_ifid_en,
   output logic             o_ifid_clr,
   output logic             o_idex_en,
   output logic             o_idex_clr,
   output logic             o_exmem_en,
   output logic             o_exmem_clr,
   output logic             o_memwb_en,
   output logic             o_memwb_clr,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cycles
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MCWAIT = 2'd1,
      DRAIN  = 2'd2,
      RSVD   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_stall;
   logic             w_run;
   logic             w_mc_hold;

   // The unused encoding behaves exactly like RUN.
   assign w_run     = (r_state == RUN) || (r_state == RSVD);
   assign w_mc_hold = ((r_state == MCWAIT) && !i_mc_done) || (w_run && i_mc_start);

   always_comb begin
      o_pc_en     = 1'b0;
      o_ifid_en   = 1'b0;
      o_ifid_clr  = 1'b0;
      o_idex_en   = 1'b0;
      o_idex_clr  = 1'b0;
      o_exmem_en  = 1'b0;
      o_exmem_clr = 1'b0;
      o_memwb_en  = 1'b0;
      o_memwb_clr = 1'b0;
      w_next      = w_run ? RUN : r_state;

      if (i_rst_n) begin
         // Start from "everything captures" and knock out per hazard.
         o_pc_en    = 1'b1;
         o_ifid_en  = 1'b1;
         o_idex_en  = 1'b1;
         o_exmem_en = 1'b1;
         o_memwb_en = 1'b1;

         if (i_dmem_busy) begin
            // Freeze the front; bubble WB so the retiring op is not committed twice.
            o_pc_en     = 1'b0;
            o_ifid_en   = 1'b0;
            o_idex_en   = 1'b0;
            o_exmem_en  = 1'b0;
            o_memwb_clr = 1'b1;
         end else if (w_mc_hold) begin
            o_pc_en     = 1'b0;
            o_ifid_en   = 1'b0;
            o_idex_en   = 1'b0;
            o_exmem_clr = 1'b1;
         end else if (w_run && i_redirect) begin
            o_ifid_clr = 1'b1;
            o_idex_clr = 1'b1;
         end else if (r_state == DRAIN) begin
            o_pc_en    = 1'b0;
            o_ifid_clr = 1'b1;
         end else if (i_load_use) begin
            o_pc_en    = 1'b0;
            o_ifid_en  = 1'b0;
            o_idex_clr = 1'b1;
         end else if (i_ifetch_busy) begin
            o_pc_en    = 1'b0;
            o_ifid_clr = 1'b1;
         end

         // A busy data memory holds every transition until it completes.
         if (!i_dmem_busy) begin
            if (w_run) begin
               if (i_mc_start)
                  w_next = MCWAIT;
               else if (i_redirect && i_ifetch_busy)
                  w_next = DRAIN;
            end else if (r_state == MCWAIT) begin
               if (i_mc_done)
                  w_next = RUN;
            end else if (r_state == DRAIN) begin
               if (!i_ifetch_busy)
                  w_next = RUN;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RUN;
         r_stall <= '0;
      end else begin
         r_state <= w_next;
         if (!o_pc_en && (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_state        = r_state;
   assign o_stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ifb, dmb, lu, rd, mcs, mcd;
   logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
   logic        exmem_en, exmem_clr, memwb_en, memwb_clr;
   logic [1:0]  state;
   logic [15:0] stall;
   logic        pc_en2, ifid_en2, ifid_clr2, idex_en2, idex_clr2;
   logic        exmem_en2, exmem_clr2, memwb_en2, memwb_clr2;
   logic [1:0]  state2;
   logic [1:0]  stall2;
   logic [8:0]  outs;

   int checks = 0;
   int errors = 0;

   // Bit order: pc, ifid en/clr, idex en/clr, exmem en/clr, memwb en/clr
   localparam logic [8:0] O_RUN   = 9'b110101010;
   localparam logic [8:0] O_DMEM  = 9'b000000011;
   localparam logic [8:0] O_MC    = 9'b000001110;
   localparam logic [8:0] O_REDIR = 9'b111111010;
   localparam logic [8:0] O_DRAIN = 9'b011101010;
   localparam logic [8:0] O_LU    = 9'b000111010;
   localparam logic [8:0] O_IFB   = 9'b011101010;
   localparam logic [8:0] O_ZERO  = 9'b000000000;

   pipe_ctrl #(.CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ifetch_busy(ifb), .i_dmem_busy(dmb), .i_load_use(lu),
      .i_redirect(rd), .i_mc_start(mcs), .i_mc_done(mcd),
      .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_clr(ifid_clr),
      .o_idex_en(idex_en), .o_idex_clr(idex_clr),
      .o_exmem_en(exmem_en), .o_exmem_clr(exmem_clr),
      .o_memwb_en(memwb_en), .o_memwb_clr(memwb_clr),
      .o_state(state), .o_stall_cycles(stall)
   );

   pipe_ctrl #(.CNT_W(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ifetch_busy(ifb), .i_dmem_busy(dmb), .i_load_use(lu),
      .i_redirect(rd), .i_mc_start(mcs), .i_mc_done(mcd),
      .o_pc_en(pc_en2), .o_ifid_en(ifid_en2), .o_ifid_clr(ifid_clr2),
      .o_idex_en(idex_en2), .o_idex_clr(idex_clr2),
      .o_exmem_en(exmem_en2), .o_exmem_clr(exmem_clr2),
      .o_memwb_en(memwb_en2), .o_memwb_clr(memwb_clr2),
      .o_state(state2), .o_stall_cycles(stall2)
   );

   assign outs = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                  exmem_en, exmem_clr, memwb_en, memwb_clr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ifb, dmb, lu, rd, mcs, mcd;
      logic [8:0] out;
      logic [1:0] st;
      int         stall;
   } vec_t;

   vec_t vecs[29];

   function automatic vec_t mk(input logic a_ifb, input logic a_dmb, input logic a_lu,
                               input logic a_rd, input logic a_mcs, input logic a_mcd,
                               input logic [8:0] a_out, input logic [1:0] a_st,
                               input int a_stall);
      vec_t v;
      v.ifb = a_ifb; v.dmb = a_dmb; v.lu = a_lu; v.rd = a_rd; v.mcs = a_mcs; v.mcd = a_mcd;
      v.out = a_out; v.st = a_st; v.stall = a_stall;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and settle before sampling.
   task automatic apply(input logic a_ifb, input logic a_dmb, input logic a_lu,
                        input logic a_rd, input logic a_mcs, input logic a_mcd);
      @(negedge clk);
      ifb = a_ifb; dmb = a_dmb; lu = a_lu; rd = a_rd; mcs = a_mcs; mcd = a_mcd;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      ifb = 0; dmb = 0; lu = 0; rd = 0; mcs = 0; mcd = 0;

      //            ifb dmb lu rd mcs mcd  out      st  stall
      vecs[0]  = mk(0, 0, 1, 0, 0, 0, O_LU,    0, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 1);
      vecs[2]  = mk(1, 0, 0, 0, 0, 0, O_IFB,   0, 1);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 2);
      vecs[4]  = mk(0, 0, 0, 0, 1, 0, O_MC,    0, 2);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, O_MC,    1, 3);
      vecs[6]  = mk(0, 0, 1, 0, 0, 0, O_MC,    1, 4);
      vecs[7]  = mk(0, 0, 0, 1, 1, 0, O_MC,    1, 5);
      vecs[8]  = mk(0, 0, 0, 0, 0, 1, O_RUN,   1, 6);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 6);
      vecs[10] = mk(1, 0, 0, 1, 0, 0, O_REDIR, 0, 6);
      vecs[11] = mk(1, 0, 0, 0, 0, 0, O_DRAIN, 2, 6);
      vecs[12] = mk(0, 0, 1, 1, 0, 0, O_DRAIN, 2, 7);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 8);
      vecs[14] = mk(0, 1, 1, 1, 0, 0, O_DMEM,  0, 8);
      vecs[15] = mk(0, 1, 1, 1, 0, 0, O_DMEM,  0, 9);
      vecs[16] = mk(0, 0, 1, 1, 0, 0, O_REDIR, 0, 10);
      vecs[17] = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 10);
      vecs[18] = mk(0, 1, 0, 0, 1, 0, O_DMEM,  0, 10);
      vecs[19] = mk(0, 0, 0, 0, 1, 0, O_MC,    0, 11);
      vecs[20] = mk(0, 1, 0, 0, 0, 1, O_DMEM,  1, 12);
      vecs[21] = mk(0, 0, 0, 0, 0, 1, O_RUN,   1, 13);
      vecs[22] = mk(1, 0, 1, 1, 0, 0, O_REDIR, 0, 13);
      vecs[23] = mk(0, 0, 0, 0, 0, 0, O_DRAIN, 2, 13);
      vecs[24] = mk(1, 0, 1, 0, 0, 0, O_LU,    0, 14);
      vecs[25] = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 15);
      vecs[26] = mk(0, 0, 0, 1, 1, 0, O_MC,    0, 15);
      vecs[27] = mk(0, 0, 0, 0, 0, 1, O_RUN,   1, 16);
      vecs[28] = mk(0, 0, 0, 0, 0, 0, O_RUN,   0, 16);

      // Reset state
      #1;
      check("reset outs", 32'(outs), 32'(O_ZERO));
      check("reset state", 32'(state), 32'd0);
      check("reset stall", 32'(stall), 32'd0);

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         apply(0, 0, 0, 0, 0, 0);
         check($sformatf("idle%0d outs", i), 32'(outs), 32'(O_RUN));
         check($sformatf("idle%0d state", i), 32'(state), 32'd0);
         check($sformatf("idle%0d stall", i), 32'(stall), 32'd0);
      end

      // Table-driven sequence
      for (int i = 0; i < 29; i++) begin
         apply(vecs[i].ifb, vecs[i].dmb, vecs[i].lu, vecs[i].rd, vecs[i].mcs, vecs[i].mcd);
         check($sformatf("vec%0d outs", i), 32'(outs), 32'(vecs[i].out));
         check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].stall));
         check($sformatf("vec%0d stall2", i), 32'(stall2),
               32'((vecs[i].stall > 3) ? 3 : vecs[i].stall));
      end

      // Asynchronous reset in the middle of MCWAIT
      apply(0, 0, 0, 0, 1, 0);
      check("mc enter outs", 32'(outs), 32'(O_MC));
      apply(0, 0, 0, 0, 0, 0);
      check("mc wait state", 32'(state), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async mc state", 32'(state), 32'd0);
      check("async mc stall", 32'(stall), 32'd0);
      check("async mc stall2", 32'(stall2), 32'd0);
      check("async mc outs", 32'(outs), 32'(O_ZERO));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post rst outs", 32'(outs), 32'(O_RUN));
      apply(0, 0, 0, 0, 0, 0);
      check("post rst state", 32'(state), 32'd0);
      check("post rst stall", 32'(stall), 32'd0);

      // Asynchronous reset in the middle of DRAIN
      apply(1, 0, 0, 1, 0, 0);
      check("drain enter outs", 32'(outs), 32'(O_REDIR));
      apply(1, 0, 0, 0, 0, 0);
      check("drain state", 32'(state), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async drain state", 32'(state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ifb = 0; rd = 0;
      #1;
      check("no drain survives outs", 32'(outs), 32'(O_RUN));
      check("no drain survives state", 32'(state), 32'd0);

      // Load-use stall counted on the following cycle
      apply(0, 0, 1, 0, 0, 0);
      check("lu outs", 32'(outs), 32'(O_LU));
      apply(0, 0, 0, 0, 0, 0);
      check("lu stall", 32'(stall), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
